// File: rtl/priority_iterator.sv
// ============================================================================
// priority_iterator : emits set-bit indices of an accepted vector, one per beat
// Rev 1.0
// ============================================================================
`default_nettype none

module priority_iterator #(
   parameter  int WIDTH     = 8,
   parameter  bit MSB_FIRST = 1'b0,
   localparam int IDX_W     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_bits,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic             out_last,
   output logic             out_empty,
   output logic [IDX_W:0]   out_beat
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mask_q,  mask_d;
   logic [IDX_W:0]     beat_q,  beat_d;

   logic [IDX_W-1:0]   w_idx;
   logic               w_scan;
   logic               w_multi;
   logic               w_any;
   logic               w_beat_hs;
   logic               w_end;
   logic               w_accept;

   // Priority encoder over the remaining mask; direction fixed at elaboration.
   if (MSB_FIRST) begin : g_msb_first
      always_comb begin
         w_idx = '0;
         for (int i = 0; i < WIDTH; i++) begin
            if (mask_q[i]) w_idx = IDX_W'(i);
         end
      end
   end else begin : g_lsb_first
      always_comb begin
         w_idx = '0;
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_q[i]) w_idx = IDX_W'(i);
         end
      end
   end

   // Outputs are forced quiet while reset is held, even mid-transaction.
   assign w_scan    = (state_q == ST_SCAN) && rst_n;
   assign w_multi   = |(mask_q & (mask_q - WIDTH'(1)));
   assign w_any     = |mask_q;
   assign w_beat_hs = w_scan && out_ready;
   assign w_end     = w_beat_hs && !w_multi;

   assign in_ready  = rst_n && (!w_scan || w_end);
   assign w_accept  = in_valid && in_ready;

   assign out_valid = w_scan;
   assign out_last  = w_scan && !w_multi;
   assign out_empty = w_scan && !w_any;
   assign out_index = w_scan ? w_idx  : '0;
   assign out_beat  = w_scan ? beat_q : '0;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      beat_d  = beat_q;
      if (w_accept) begin
         state_d = ST_SCAN;
         mask_d  = in_bits;
         beat_d  = '0;
      end else if (w_end) begin
         state_d = ST_IDLE;
         mask_d  = '0;
         beat_d  = '0;
      end else if (w_beat_hs) begin
         mask_d  = mask_q & ~(WIDTH'(1) << w_idx);
         beat_d  = beat_q + (IDX_W + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         beat_q  <= beat_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_priority_iterator.sv
// ============================================================================
// tb_priority_iterator : scoreboard bench, WIDTH=8/LSB-first and WIDTH=5/MSB-first
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_priority_iterator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid  [2];
   logic       in_ready  [2];
   logic [7:0] in_bits   [2];
   logic       out_valid [2];
   logic       out_ready [2];
   logic [2:0] out_index [2];
   logic       out_last  [2];
   logic       out_empty [2];
   logic [3:0] out_beat  [2];

   always #5 clk = ~clk;

   priority_iterator #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .in_bits   (in_bits[0]),
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0]),
      .out_index (out_index[0]),
      .out_last  (out_last[0]),
      .out_empty (out_empty[0]),
      .out_beat  (out_beat[0])
   );

   priority_iterator #(.WIDTH(5), .MSB_FIRST(1'b1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .in_bits   (in_bits[1][4:0]),
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1]),
      .out_index (out_index[1]),
      .out_last  (out_last[1]),
      .out_empty (out_empty[1]),
      .out_beat  (out_beat[1])
   );

   typedef struct packed {
      logic [2:0] idx;
      logic       last;
      logic       empty;
      logic [3:0] beat;
   } beat_t;

   beat_t q0[$];
   beat_t q1[$];
   int    n_checks = 0;
   int    n_passed = 0;
   logic  tog_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic beat_t qfront(input int d);
      return (d == 0) ? q0[0] : q1[0];
   endfunction

   task automatic qpush(input int d, input beat_t b);
      if (d == 0) q0.push_back(b);
      else        q1.push_back(b);
   endtask

   task automatic qpop(input int d);
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endtask

   task automatic qclear(input int d);
      if (d == 0) q0.delete();
      else        q1.delete();
   endtask

   // Reference: list the set indices in emission order, then number them.
   task automatic push_vec(input int d, input logic [7:0] v);
      int    order[$];
      int    w;
      beat_t b;
      w = (d == 0) ? 8 : 5;
      if (d == 0) begin
         for (int i = 0; i < w; i++) if (v[i]) order.push_back(i);
      end else begin
         for (int i = w - 1; i >= 0; i--) if (v[i]) order.push_back(i);
      end
      if (order.size() == 0) begin
         b = '{idx: 3'd0, last: 1'b1, empty: 1'b1, beat: 4'd0};
         qpush(d, b);
      end else begin
         for (int k = 0; k < order.size(); k++) begin
            b.idx   = 3'(order[k]);
            b.last  = (k == order.size() - 1);
            b.empty = 1'b0;
            b.beat  = 4'(k);
            qpush(d, b);
         end
      end
   endtask

   // Monitor: compare every cycle away from the active edge, then advance the model.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int    sz;
         beat_t h;
         sz = qsize(d);
         check($sformatf("d%0d in_ready", d), 32'(in_ready[d]),
               32'(rst_n && (sz == 0 || (sz == 1 && out_ready[d]))));
         check($sformatf("d%0d out_valid", d), 32'(out_valid[d]), 32'(rst_n && sz != 0));
         if (rst_n && sz != 0) begin
            h = qfront(d);
            check($sformatf("d%0d beat{idx,last,empty,beat}", d),
                  32'({out_index[d], out_last[d], out_empty[d], out_beat[d]}), 32'(h));
         end else begin
            check($sformatf("d%0d idle_outs", d),
                  32'({out_index[d], out_last[d], out_empty[d], out_beat[d]}), 32'(0));
         end
         if (!rst_n) begin
            qclear(d);
         end else begin
            if (sz != 0 && out_ready[d]) qpop(d);
            if (in_valid[d] && in_ready[d]) push_vec(d, in_bits[d]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (tog_en) out_ready[1] = ~out_ready[1];
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic offer(input int d, input logic [7:0] v);
      logic acc;
      acc         = 1'b0;
      in_valid[d] = 1'b1;
      in_bits[d]  = v;
      for (int i = 0; i < 60 && !acc; i++) begin
         @(negedge clk);
         if (in_ready[d]) acc = 1'b1;
         tick();
      end
      in_valid[d] = 1'b0;
      check($sformatf("d%0d offer_accepted", d), 32'(acc), 32'(1));
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         in_valid[d]  = 1'b0;
         in_bits[d]   = 8'h00;
         out_ready[d] = 1'b1;
      end
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // Directed: sparse vector, all-zero vector, back-to-back held valid.
      offer(0, 8'hA4);
      idle(4);
      offer(0, 8'h00);
      idle(3);
      offer(0, 8'h81);
      offer(0, 8'h10);
      idle(4);

      // Directed: MSB-first all-ones with a toggling consumer.
      tog_en = 1'b1;
      offer(1, 8'h1F);
      idle(12);
      tog_en       = 1'b0;
      out_ready[1] = 1'b1;
      idle(2);

      // Directed: reset in the middle of a transaction discards it.
      offer(0, 8'hFF);
      offer(1, 8'h1F);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      in_bits[0] = 8'hFF;
      in_bits[1] = 8'hFF;
      idle(6);

      // Random traffic with stalls, ignored in_bits changes and rare resets.
      for (int c = 0; c < 3000; c++) begin
         for (int d = 0; d < 2; d++) begin
            int sel;
            sel          = $urandom_range(0, 9);
            in_valid[d]  = ($urandom_range(0, 3) != 0);
            in_bits[d]   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            out_ready[d] = ($urandom_range(0, 3) != 0);
         end
         rst_n = ($urandom_range(0, 299) != 0);
         tick();
      end

      rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b1;
      end
      for (int i = 0; i < 300 && (q0.size() + q1.size()) != 0; i++) tick();
      idle(2);
      check("drain_pending_beats", 32'(q0.size() + q1.size()), 32'(0));

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
